pe_st_unit_flow_control: RTL
============================

# pe_st_unit_flow_control

Store-side memory unit flow control for a PE. It is the receiving end of the func-unit store interface. It accepts one result per store instruction from the func unit via the `func_unit_rdy` / `memory_unit_rdy` handshake and queues the address/data pair in a small FIFO. It then drains the FIFO to the data-memory write port with a req/gnt handshake, so a stalled memory bank does not block the func unit until the FIFO is full.

## Interface
Parameters:
- `DATA_W`, 32, width of a stored word
- `ADDR_W`, 10, data-memory word address width
- `FIFO_DEPTH`, 4, store queue entries; power of two, ≥2

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `st_en`  in  1  current instruction contains a store (decoder)
- `st_addr`  in  ADDR_W  store address; valid while `st_en`
- `instr_done`  in  1  current instruction retires this cycle
- `func_unit_rdy`  in  1  func unit presents valid store data
- `func_unit_data`  in  DATA_W  store data; valid with `func_unit_rdy`
- `memory_unit_rdy`  out  1  data captured this cycle (combinational)
- `mem_wr_req`  out  1  FIFO head valid, write requested
- `mem_wr_addr`  out  ADDR_W  FIFO head address
- `mem_wr_data`  out  DATA_W  FIFO head data
- `mem_wr_gnt`  in  1  memory accepts the head this cycle
- `st_occupancy`  out  $clog2(FIFO_DEPTH)+1  entries queued
- `st_idle`  out  1  FIFO empty and no capture this cycle

## Operation
- Capture condition: `push = st_en & func_unit_rdy & ~captured & ~full`, where `full = (st_occupancy == FIFO_DEPTH)` is computed from registered count only.
- `memory_unit_rdy = push`. It never asserts when `st_en`=0, when `captured`=1, or when the FIFO is full.
- `captured` state (one-capture-per-instruction guard):
  - reset→0.
  - 0→1 on `push & ~instr_done`.
  - 1→0 on `instr_done`.
  - `push & instr_done` in the same cycle leaves it at 0.
- FIFO: circular buffer with wr_ptr/rd_ptr of $clog2(FIFO_DEPTH) bits. Pointers wrap modulo FIFO_DEPTH.
  - `push` writes {`st_addr`, `func_unit_data`} at wr_ptr.
- Drain: `mem_wr_req = (st_occupancy != 0)`. `mem_wr_addr`/`mem_wr_data` are driven from the rd_ptr entry.
  - `pop = mem_wr_req & mem_wr_gnt`; `pop` advances rd_ptr.
  - `mem_wr_gnt` while empty is ignored.
- Count: +1 on push only, −1 on pop only, unchanged on push & pop. It never exceeds FIFO_DEPTH and never underflows.
- When full, a same-cycle pop does not enable a push. The push is accepted on the following cycle.
- Entries are written to memory strictly in capture order.
- `st_idle = (st_occupancy == 0) & ~push`.
- Reset values: `captured`, pointers, `st_occupancy` = 0; FIFO storage = 0; `mem_wr_req`=0; `mem_wr_addr`/`mem_wr_data`=0; `st_idle`=1; `memory_unit_rdy`=0 (given `st_en`=0).
- Reset asserted mid-operation discards all queued stores immediately. Outputs take reset values asynchronously.

## Timing
- Capture is zero-latency: the func unit sees `memory_unit_rdy` in the same cycle as `func_unit_rdy`.
- Captured data reaches the memory port one cycle later: `mem_wr_req` rises in cycle N+1 after a push in cycle N, if the FIFO was empty.
- With continuous `mem_wr_gnt`=1, pop throughput is one entry per cycle. A push in every other instruction never fills the FIFO.
- `mem_wr_req`, `mem_wr_addr` and `mem_wr_data` stay stable while `mem_wr_req`=1 and `mem_wr_gnt`=0.
- The `full` → `memory_unit_rdy` path depends on registered state only. There is no combinational path from `mem_wr_gnt` to `memory_unit_rdy`.
- Assertions required:
  - `memory_unit_rdy` → `st_en & func_unit_rdy`
  - `mem_wr_req` never falls without a pop or reset
  - occupancy is always ≤ FIFO_DEPTH

## Test plan
- Single store: `st_en`=1, `st_addr`=0x05, `func_unit_rdy`=1, data=0xDEADBEEF, `instr_done` one cycle later, `mem_wr_gnt`=1.
  - `memory_unit_rdy`=1 in cycle 0.
  - `mem_wr_req`=1 in cycle 1 with addr 0x05 / data 0xDEADBEEF.
  - Occupancy back to 0 in cycle 2; `st_idle`=1.
- Capture guard: `func_unit_rdy` held high 3 cycles before `instr_done`.
  - Exactly one `memory_unit_rdy` pulse and one queued entry.
- Full FIFO: `mem_wr_gnt`=0, four stores (addr 1–4, data 0x10–0x40) → occupancy 4.
  - A fifth store sees `memory_unit_rdy`=0.
  - `mem_wr_gnt`=1 for one cycle → fifth store accepted the next cycle.
  - Drain order is addresses 1,2,3,4,5.
- Wrap-around: 10 back-to-back stores with random 0/1 `mem_wr_gnt`.
  - All 10 written in order, with no loss or duplication.
  - Occupancy never exceeds 4.
- Same-cycle `push & instr_done`: the next instruction's store is accepted on the next cycle without a stall.
- Reset mid-drain: with occupancy 3, pull `rst` low.
  - `mem_wr_req`=0 and occupancy 0 immediately.
  - After release, a new store to 0x7F is the first write seen.

Source files
------------

// File: rtl/pe_st_unit_flow_control.sv
// Store-side memory unit flow control for a PE.
// Captures one store per instruction into a FIFO and drains it to data memory.
module pe_st_unit_flow_control #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          st_en,
  input  logic [ADDR_W-1:0]             st_addr,
  input  logic                          instr_done,
  input  logic                          func_unit_rdy,
  input  logic [DATA_W-1:0]             func_unit_data,
  output logic                          memory_unit_rdy,
  output logic                          mem_wr_req,
  output logic [ADDR_W-1:0]             mem_wr_addr,
  output logic [DATA_W-1:0]             mem_wr_data,
  input  logic                          mem_wr_gnt,
  output logic [$clog2(FIFO_DEPTH):0]   st_occupancy,
  output logic                          st_idle
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              captured;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] data_q [FIFO_DEPTH];

  // Handshake decode; full only looks at the registered count
  always_comb begin
    full  = (count == CW'(FIFO_DEPTH));
    empty = (count == '0);
    push  = st_en & func_unit_rdy & ~captured & ~full;
    pop   = ~empty & mem_wr_gnt;
  end

  // One capture per instruction; retire clears the guard
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      captured <= 1'b0;
    end else if (instr_done) begin
      captured <= 1'b0;
    end else if (push) begin
      captured <= 1'b1;
    end
  end

  // Queue storage written at the tail
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (push) begin
      addr_q[wr_ptr] <= st_addr;
      data_q[wr_ptr] <= func_unit_data;
    end
  end

  // Circular pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Occupancy tracks push/pop balance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head of queue drives the memory write port
  always_comb begin
    memory_unit_rdy = push;
    mem_wr_req      = ~empty;
    mem_wr_addr     = addr_q[rd_ptr];
    mem_wr_data     = data_q[rd_ptr];
    st_occupancy    = count;
    st_idle         = empty & ~push;
  end

  a_rdy_src: assert property (@(posedge clk) disable iff (!rst)
    memory_unit_rdy |-> (st_en & func_unit_rdy));

  a_req_hold: assert property (@(posedge clk) disable iff (!rst)
    (mem_wr_req & ~pop) |=> mem_wr_req);

  a_occ_max: assert property (@(posedge clk) disable iff (!rst)
    st_occupancy <= CW'(FIFO_DEPTH));

endmodule
